// File: rtl/parity_pkg.sv
// Shared constants and the per-lane parity helper for the parity lane codec.
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // The helper works on fixed maximum widths; callers zero-extend and truncate.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_LANES      = 256;

    function automatic logic [MAX_LANES-1:0] lane_parity(
        input logic [MAX_DATA_WIDTH-1:0] data,
        input logic                      odd,
        input int                        data_width,
        input int                        lane_width
    );
        logic [MAX_LANES-1:0] par;
        par = '0;
        for (int k = 0; k < MAX_DATA_WIDTH; k++) begin
            if (k < data_width) begin
                par[8'(k / lane_width)] = par[8'(k / lane_width)] ^ data[8'(k)];
            end
        end
        return par ^ {MAX_LANES{odd}};
    endfunction

endpackage

// File: rtl/parity_lane_codec_if.sv
// Stream bus of the parity lane codec: input beat side (s_*) and output beat side (m_*).
interface parity_lane_codec_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [NUM_LANES-1:0]  s_par;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [NUM_LANES-1:0]  m_par;
    logic [NUM_LANES-1:0]  m_err;

    modport slave (
        input  s_valid, s_data, s_par, m_ready,
        output s_ready, m_valid, m_data, m_par, m_err
    );

    modport master (
        output s_valid, s_data, s_par, m_ready,
        input  s_ready, m_valid, m_data, m_par, m_err
    );
endinterface

// File: rtl/parity_skid_buf.sv
// Two-entry valid/ready skid buffer: main entry drives the output, skid absorbs one
// beat of backpressure so in_ready can stay registered.
module parity_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else if (!out_valid || drain) begin
            // in_ready is low whenever skid is full, so no accept collides with the refill
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
            end
            in_ready <= 1'b1;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            in_ready   <= 1'b0;
        end else begin
            in_ready <= !skid_valid;
        end
    end
endmodule

// File: rtl/parity_lane_codec.sv
// Per-lane parity generator/checker with a skid-buffered stream path and a
// saturating errored-beat counter.
module parity_lane_codec
    import parity_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_check,
    input  logic                 cfg_odd,
    input  logic                 clr_err,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] err_cnt,
    parity_lane_codec_if.slave   bus
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int BEAT_W    = DATA_WIDTH + 2 * NUM_LANES;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    if ((DATA_WIDTH % LANE_WIDTH) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("parity_lane_codec: DATA_WIDTH must be a multiple of LANE_WIDTH and at most MAX_DATA_WIDTH");
    end

    logic [MAX_DATA_WIDTH-1:0] data_ext;
    logic [NUM_LANES-1:0]      lane_par;
    logic [NUM_LANES-1:0]      beat_par;
    logic [NUM_LANES-1:0]      beat_err;
    logic                      chk_mode;
    logic                      accept;
    logic                      acc_err;
    logic [BEAT_W-1:0]         beat_in;
    logic [BEAT_W-1:0]         beat_out;

    always_comb begin
        data_ext = '0;
        data_ext[DATA_WIDTH-1:0] = bus.s_data;
    end

    assign lane_par = NUM_LANES'(lane_parity(data_ext, cfg_odd == PAR_ODD, DATA_WIDTH, LANE_WIDTH));
    assign chk_mode = (cfg_check == MODE_CHK);
    assign beat_err = chk_mode ? (lane_par ^ bus.s_par) : '0;
    assign beat_par = chk_mode ? bus.s_par : lane_par;
    assign beat_in  = {bus.s_data, beat_par, beat_err};

    assign accept  = bus.s_valid & bus.s_ready;
    assign acc_err = accept & (|beat_err);

    parity_skid_buf #(.WIDTH(BEAT_W)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (bus.s_valid),
        .in_ready  (bus.s_ready),
        .in_data   (beat_in),
        .out_valid (bus.m_valid),
        .out_ready (bus.m_ready),
        .out_data  (beat_out)
    );

    assign bus.m_data = beat_out[BEAT_W-1 -: DATA_WIDTH];
    assign bus.m_par  = beat_out[2*NUM_LANES-1 -: NUM_LANES];
    assign bus.m_err  = beat_out[NUM_LANES-1:0];

    // A clear coinciding with an errored acceptance counts that beat after clearing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clr_err && acc_err) begin
            err_cnt    <= CNT_ONE;
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (acc_err) begin
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_lane_codec.sv
// Randomized and directed bench for parity_lane_codec against a queue-based beat model.
module tb_parity_lane_codec;
    import parity_pkg::*;

    localparam int DW = 32;
    localparam int NL = 4;
    localparam int CW = 2;
    localparam int CNT_SAT = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] d;
        logic [NL-1:0] p;
        logic [NL-1:0] e;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_check;
    logic          cfg_odd;
    logic          clr_err;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;

    parity_lane_codec_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

    parity_lane_codec #(.DATA_WIDTH(DW), .LANE_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_check  (cfg_check),
        .cfg_odd    (cfg_odd),
        .clr_err    (clr_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    beat_t         q[$];
    logic [DW-1:0] out_log[$];
    logic          exp_ready = 1'b0;
    logic          zero_flag = 1'b1;
    logic          exp_sticky = 1'b0;
    int            exp_cnt = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Parity from the definition: lane plus parity bit has an even (or odd) ones count.
    function automatic logic [NL-1:0] ref_par(input logic [DW-1:0] d, input logic odd);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) begin
            r[i] = 1'(($countones(d[i*8 +: 8]) + int'(odd)) % 2);
        end
        return r;
    endfunction

    task automatic check_all();
        chk_eq("s_ready", 32'(bus.s_ready), 32'(exp_ready));
        chk_eq("m_valid", 32'(bus.m_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk_eq("m_data", bus.m_data, q[0].d);
            chk_eq("m_par", 32'(bus.m_par), 32'(q[0].p));
            chk_eq("m_err", 32'(bus.m_err), 32'(q[0].e));
        end else if (zero_flag) begin
            chk_eq("m_data_rst", bus.m_data, 32'h0);
            chk_eq("m_par_rst", 32'(bus.m_par), 32'h0);
            chk_eq("m_err_rst", 32'(bus.m_err), 32'h0);
        end
        chk_eq("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk_eq("err_sticky", 32'(err_sticky), 32'(exp_sticky));
    endtask

    // Drive one cycle at the falling edge, advance the model at the rising edge,
    // then check outputs at the next falling edge.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic [NL-1:0] p,
                        input logic chk, input logic odd, input logic mr,
                        input logic clr, input logic rn, output logic acc);
        beat_t b;
        logic  drain;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_par   = p;
        bus.m_ready = mr;
        cfg_check   = chk;
        cfg_odd     = odd;
        clr_err     = clr;
        rstn        = rn;
        b.d = d;
        b.p = (chk == MODE_CHK) ? p : ref_par(d, odd);
        b.e = (chk == MODE_CHK) ? (ref_par(d, odd) ^ p) : '0;
        acc   = rn && v && exp_ready;
        drain = (q.size() > 0) && mr;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            exp_cnt    = 0;
            exp_sticky = 1'b0;
            exp_ready  = 1'b0;
            zero_flag  = 1'b1;
            acc        = 1'b0;
        end else begin
            if (drain) begin
                out_log.push_back(q[0].d);
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(b);
                zero_flag = 1'b0;
            end
            if (clr) begin
                exp_cnt    = 0;
                exp_sticky = 1'b0;
            end
            if (acc && (b.e != '0)) begin
                if (exp_cnt < CNT_SAT) exp_cnt++;
                exp_sticky = 1'b1;
            end
            exp_ready = (q.size() < 2);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic mr);
        logic a;
        tick(1'b0, '0, '0, MODE_GEN, PAR_EVEN, mr, 1'b0, 1'b1, a);
    endtask

    initial begin
        logic a;
        int   nxt;
        int   got;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_par   = '0;
        bus.m_ready = 1'b0;
        cfg_check   = 1'b0;
        cfg_odd     = 1'b0;
        clr_err     = 1'b0;
        rstn        = 1'b0;
        @(negedge clk);

        tick(1'b0, '0, '0, MODE_GEN, PAR_EVEN, 1'b1, 1'b0, 1'b0, a);
        tick(1'b1, 32'h55, '0, MODE_GEN, PAR_EVEN, 1'b1, 1'b0, 1'b0, a);
        chk_eq("rst_s_ready", 32'(bus.s_ready), 32'h0);
        idle(1'b1);
        chk_eq("ready_after_rst", 32'(bus.s_ready), 32'h1);

        tick(1'b1, 32'h0000_0103, '0, MODE_GEN, PAR_EVEN, 1'b1, 1'b0, 1'b1, a);
        chk_eq("gen_even_valid", 32'(bus.m_valid), 32'h1);
        chk_eq("gen_even_par", 32'(bus.m_par), 32'h2);
        tick(1'b1, 32'h0000_0103, '0, MODE_GEN, PAR_ODD, 1'b1, 1'b0, 1'b1, a);
        chk_eq("gen_odd_par", 32'(bus.m_par), 32'hd);
        tick(1'b1, 32'h0000_0103, 4'b1101, MODE_CHK, PAR_ODD, 1'b1, 1'b0, 1'b1, a);
        chk_eq("chk_ok_err", 32'(bus.m_err), 32'h0);
        chk_eq("chk_ok_cnt", 32'(err_cnt), 32'h0);
        tick(1'b1, 32'h0000_0103, 4'b1100, MODE_CHK, PAR_ODD, 1'b1, 1'b0, 1'b1, a);
        chk_eq("chk_bad_err", 32'(bus.m_err), 32'h1);
        chk_eq("chk_bad_cnt", 32'(err_cnt), 32'h1);
        chk_eq("chk_bad_sticky", 32'(err_sticky), 32'h1);
        idle(1'b1);

        out_log.delete();
        nxt = 1;
        for (int k = 0; k < 24 && (nxt <= 6 || q.size() > 0); k++) begin
            tick(nxt <= 6, DW'(nxt), '0, MODE_GEN, PAR_EVEN, !(k >= 3 && k <= 5), 1'b0, 1'b1, a);
            if (a) nxt++;
            if (k == 3) chk_eq("bp_ready_drop", 32'(bus.s_ready), 32'h0);
        end
        chk_eq("bp_count", 32'(out_log.size()), 32'd6);
        for (int i = 0; i < out_log.size() && i < 6; i++) begin
            chk_eq("bp_order", out_log[i], 32'(i + 1));
        end

        tick(1'b0, '0, '0, MODE_GEN, PAR_EVEN, 1'b1, 1'b1, 1'b1, a);
        got = 0;
        for (int k = 0; k < 20 && got < 5; k++) begin
            tick(1'b1, 32'h0000_0103, 4'b1100, MODE_CHK, PAR_ODD, 1'b1, 1'b0, 1'b1, a);
            if (a) got++;
        end
        chk_eq("sat_beats", 32'(got), 32'd5);
        chk_eq("cnt_sat", 32'(err_cnt), 32'h3);
        tick(1'b1, 32'h0000_0103, 4'b1100, MODE_CHK, PAR_ODD, 1'b1, 1'b1, 1'b1, a);
        chk_eq("clr_coincide_cnt", 32'(err_cnt), 32'h1);
        chk_eq("clr_coincide_sticky", 32'(err_sticky), 32'h1);
        idle(1'b1);

        tick(1'b1, 32'hA1, '0, MODE_GEN, PAR_EVEN, 1'b0, 1'b0, 1'b1, a);
        tick(1'b1, 32'hA2, '0, MODE_GEN, PAR_EVEN, 1'b0, 1'b0, 1'b1, a);
        tick(1'b1, 32'hA3, '0, MODE_GEN, PAR_EVEN, 1'b0, 1'b0, 1'b1, a);
        chk_eq("full_before_rst", 32'(q.size()), 32'd2);
        tick(1'b1, 32'hA3, '0, MODE_GEN, PAR_EVEN, 1'b1, 1'b0, 1'b0, a);
        chk_eq("rst_mid_valid", 32'(bus.m_valid), 32'h0);
        chk_eq("rst_mid_ready", 32'(bus.s_ready), 32'h0);
        chk_eq("rst_mid_cnt", 32'(err_cnt), 32'h0);
        idle(1'b1);
        chk_eq("rst_rel_ready", 32'(bus.s_ready), 32'h1);
        idle(1'b1);
        chk_eq("rst_no_stale", 32'(bus.m_valid), 32'h0);

        for (int k = 0; k < 3000; k++) begin
            tick(($urandom % 4) != 0, DW'($urandom), NL'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom % 3) != 0, ($urandom % 20) == 0, ($urandom % 150) != 0, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/parity_lane_codec.md
Name: parity_lane_codec

Overview:
- Parametrised parity generator and checker, one parity bit per lane of a multi-lane data word.
- Runtime selection of generate or check mode, and of odd or even parity.
- Full valid/ready handshake on both sides, with a 2-entry skid buffer so it sustains one beat per cycle and keeps ready registered.
- Sits between a byte-oriented source (e.g. UART/packet path) and its sink; accumulates an error count for status registers.

Parameters:
- DATA_WIDTH, 32, payload width in bits; must be a multiple of LANE_WIDTH (elaboration error otherwise).
- LANE_WIDTH, 8, bits covered by each parity bit.
- CNT_WIDTH, 16, width of the saturating error counter.
- NUM_LANES (localparam), DATA_WIDTH/LANE_WIDTH, number of parity bits.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- cfg_check  in  1  mode: 0 = generate, 1 = check; sampled per accepted beat.
- cfg_odd  in  1  parity type: 1 = odd (lane plus parity bit has an odd count of ones), 0 = even; sampled per accepted beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input ready (registered).
- s_data  in  DATA_WIDTH  input payload.
- s_par  in  NUM_LANES  received parity, lane i = bit i; ignored in generate mode.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  payload, passed through unchanged.
- m_par  out  NUM_LANES  generate mode: computed parity; check mode: s_par passed through.
- m_err  out  NUM_LANES  per-lane mismatch flags; always 0 in generate mode.
- clr_err  in  1  single-cycle clear of err_sticky and err_cnt.
- err_sticky  out  1  set by any errored beat; held until clr_err.
- err_cnt  out  CNT_WIDTH  count of errored beats, saturating.

Behaviour:
- Lane parity: p[i] = XOR of s_data[i*LANE_WIDTH +: LANE_WIDTH], XORed with cfg_odd.
- Check mode: m_err[i] = p[i] XOR s_par[i].
- A beat is accepted when s_valid && s_ready. Parity and error are computed combinationally from that beat and stored with it.
- Latency: accepted beat appears on m_* the next cycle when the output is empty. Throughput is 1 beat/cycle while m_ready is held high.
- Skid buffer has two entries, main (drives m_*) and skid.
  - s_ready = skid entry empty, registered.
  - If the main entry holds data and m_ready = 0, an accepted beat goes to skid and s_ready drops the next cycle.
  - When main drains, skid moves to main in the same cycle and s_ready rises the next cycle.
- Output stability: m_data, m_par and m_err stay stable while m_valid && !m_ready. Data is never dropped or duplicated.
- Reset (rstn = 0 at a clock edge): m_valid = 0, s_ready = 0, m_data, m_par and m_err = 0, err_sticky = 0, err_cnt = 0.
  - s_ready becomes 1 at the first edge with rstn = 1.
  - Reset mid-transfer discards both entries; no partial beat is emitted.
- Error accounting, evaluated at acceptance (not at output):
  - An accepted beat with any m_err bit set increments err_cnt by 1 (per beat, not per lane) and sets err_sticky.
  - err_cnt saturates at all ones.
  - If clr_err and an errored acceptance fall in the same cycle, the clear applies first: err_cnt = 1, err_sticky = 1.
- Mode/parity changes between beats take effect on the next accepted beat. Beats already buffered keep their original result.

Decomposition:
- Package parity_pkg holds:
  - constants PAR_EVEN = 1'b0, PAR_ODD = 1'b1, MODE_GEN = 1'b0, MODE_CHK = 1'b1;
  - function lane_parity(data, odd), returning one bit per lane.
- One sub-module: parity_skid_buf, a generic 2-entry valid/ready skid buffer with parameter WIDTH. It carries {data, par, err}.
- Top level holds the parity/check logic and the error counter.

Test Plan (DATA_WIDTH 32, LANE_WIDTH 8):
- Generate even: cfg_check = 0, cfg_odd = 0, s_data = 0x0000_0103, m_ready = 1 -> next cycle m_valid = 1, m_data = 0x0000_0103, m_par = 4'b0010, m_err = 0.
- Generate odd: same data, cfg_odd = 1 -> m_par = 4'b1101.
- Check: cfg_check = 1, cfg_odd = 1, s_data = 0x0000_0103.
  - s_par = 4'b1101 -> m_err = 0, err_cnt unchanged.
  - s_par = 4'b1100 -> m_err = 4'b0001, err_sticky = 1, err_cnt = 1.
- Backpressure: stream 6 beats (0x1..0x6) with m_ready low for 3 cycles mid-stream -> s_ready drops one cycle after the skid fills; output sequence is exactly 0x1..0x6 with no loss or repeat; m_* stable while stalled.
- Counter: CNT_WIDTH forced to 2; send 5 errored beats -> err_cnt = 3 (saturated). Then clr_err coincident with an errored beat -> err_cnt = 1, err_sticky = 1.
- Reset mid-operation: both entries full, rstn = 0 for 1 cycle -> m_valid = 0, s_ready = 0, err_cnt = 0 after that edge; s_ready = 1 one edge after release; no stale beat emitted.
